updown_bcd_counter: RTL and testbench

- Edge-triggered decimal up/down counter, range 0..MAX_COUNT, with a registered two-digit BCD view of the count.
- Sits behind the LCD controller. The controller pulses or holds `plus`/`minus` for several cycles. The controller reads the `bcd` nibbles and prepends 0x3 to form ASCII digits.
- One clock domain: the LCD enable clock.

---
 rtl/updown_bcd_counter_if.sv | 22 ++
 rtl/updown_bcd_counter.sv | 84 ++++++++
 tb/tb_updown_bcd_counter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/updown_bcd_counter_if.sv
// updown_bcd_counter_if: step requests in, binary and BCD count out.
// Signals: plus, minus (requests); count[6:0] (binary); bcd[7:0] (two digits).
interface updown_bcd_counter_if;
  logic       plus;
  logic       minus;
  logic [6:0] count;
  logic [7:0] bcd;

  modport master (
    output plus,
    output minus,
    input  count,
    input  bcd
  );

  modport slave (
    input  plus,
    input  minus,
    output count,
    output bcd
  );
endinterface

// File: rtl/updown_bcd_counter.sv
// updown_bcd_counter: edge-triggered 0..MAX_COUNT up/down counter with a
// registered two-digit BCD view (bcd lags count by one cycle).
// Ports: clk, resetn (sync, active-low), bus (slave: plus, minus -> count, bcd).
// Build option: UPDOWN_BCD_SATURATE_EN saturates at 0/MAX_COUNT instead of wrapping.
module updown_bcd_counter #(
  parameter int MAX_COUNT = 99
) (
  input  logic                  clk,
  input  logic                  resetn,
  updown_bcd_counter_if.slave   bus
);

  localparam logic [6:0] MAXC = 7'(MAX_COUNT);

  logic       plus_q;
  logic       minus_q;
  logic [6:0] count_q;
  logic [7:0] bcd_q;
  logic       inc;
  logic       dec;
  logic [6:0] count_d;
  logic [3:0] tens;
  logic [3:0] ones;

  assign inc = bus.plus & ~plus_q;
  assign dec = bus.minus & ~minus_q;

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      inc && !dec: begin
        if (count_q == MAXC) begin
`ifdef UPDOWN_BCD_SATURATE_EN
          count_d = MAXC;
`else
          count_d = '0;
`endif
        end else begin
          count_d = count_q + 7'd1;
        end
      end
      dec && !inc: begin
        if (count_q == '0) begin
`ifdef UPDOWN_BCD_SATURATE_EN
          count_d = '0;
`else
          count_d = MAXC;
`endif
        end else begin
          count_d = count_q - 7'd1;
        end
      end
      default: count_d = count_q;
    endcase
  end

  // Tens digit by threshold compare; the ones digit is 0..9, so the low
  // nibble of (count - 10*tens) taken mod 16 is already exact.
  always_comb begin
    tens = '0;
    for (int i = 1; i <= 9; i++) begin
      if (count_q >= 7'(10 * i)) tens = 4'(i);
    end
    ones = count_q[3:0] - (tens * 4'd10);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      plus_q  <= 1'b0;
      minus_q <= 1'b0;
      count_q <= '0;
      bcd_q   <= '0;
    end else begin
      plus_q  <= bus.plus;
      minus_q <= bus.minus;
      count_q <= count_d;
      bcd_q   <= {tens, ones};
    end
  end

  assign bus.count = count_q;
  assign bus.bcd   = bcd_q;

endmodule

// File: tb/tb_updown_bcd_counter.sv
// tb_updown_bcd_counter: directed steps with a cycle model feeding a
// scoreboard queue, plus fixed-value checks at the interesting points.
module tb_updown_bcd_counter;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  updown_bcd_counter_if bus ();

  updown_bcd_counter #(.MAX_COUNT(99)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] c;
    logic [7:0] b;
  } exp_t;

  exp_t q[$];

  int m_cnt;
  int m_bcd;
  bit m_pq;
  bit m_mq;

  task automatic chk7(input string tag, input logic [6:0] obs,
                      input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit p, input bit m, input bit r);
    bit inc;
    bit dec;
    int old;
    old = m_cnt;
    if (!r) begin
      m_cnt = 0;
      m_bcd = 0;
      m_pq  = 0;
      m_mq  = 0;
    end else begin
      inc = p && !m_pq;
      dec = m && !m_mq;
      if (inc && !dec) begin
`ifdef UPDOWN_BCD_SATURATE_EN
        m_cnt = (old == 99) ? 99 : old + 1;
`else
        m_cnt = (old == 99) ? 0 : old + 1;
`endif
      end else if (dec && !inc) begin
`ifdef UPDOWN_BCD_SATURATE_EN
        m_cnt = (old == 0) ? 0 : old - 1;
`else
        m_cnt = (old == 0) ? 99 : old - 1;
`endif
      end
      m_bcd = ((old / 10) << 4) | (old % 10);
      m_pq  = p;
      m_mq  = m;
    end
  endtask

  task automatic step(input bit p, input bit m, input bit r);
    exp_t e;
    exp_t g;
    @(negedge clk);
    bus.plus  = p;
    bus.minus = m;
    resetn    = r;
    @(posedge clk);
    model_edge(p, m, r);
    e.c = 7'(m_cnt);
    e.b = 8'(m_bcd);
    q.push_back(e);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      g = q.pop_front();
      chk7("sb_count", bus.count, g.c);
      chk8("sb_bcd", bus.bcd, g.b);
    end
  endtask

  task automatic pulse_up();
    step(1, 0, 1);
    step(0, 0, 1);
  endtask

  task automatic do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    m_cnt     = 0;
    m_bcd     = 0;
    m_pq      = 0;
    m_mq      = 0;
    resetn    = 1'b0;
    bus.plus  = 1'b0;
    bus.minus = 1'b0;

    // reset then idle
    do_reset();
    chk7("rst_count", bus.count, 7'd0);
    chk8("rst_bcd", bus.bcd, 8'h00);
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    chk7("idle_count", bus.count, 7'd0);
    chk8("idle_bcd", bus.bcd, 8'h00);

    // held level gives a single step
    step(1, 0, 1);
    chk7("hold_first", bus.count, 7'd1);
    for (int i = 0; i < 4; i++) step(1, 0, 1);
    chk7("hold_once", bus.count, 7'd1);
    chk8("hold_bcd", bus.bcd, 8'h01);
    step(0, 0, 1);
    for (int i = 0; i < 11; i++) pulse_up();
    chk7("twelve_count", bus.count, 7'd12);
    chk8("twelve_bcd", bus.bcd, 8'h12);

    // down wrap at 0
    do_reset();
    step(0, 1, 1);
    step(0, 0, 1);
`ifdef UPDOWN_BCD_SATURATE_EN
    chk7("dnwrap_count", bus.count, 7'd0);
    chk8("dnwrap_bcd", bus.bcd, 8'h00);
`else
    chk7("dnwrap_count", bus.count, 7'd99);
    chk8("dnwrap_bcd", bus.bcd, 8'h99);
`endif

    // up wrap at 99
    for (int i = 0; i < 200 && m_cnt != 99; i++) pulse_up();
    chk7("pre99_count", bus.count, 7'd99);
    chk8("pre99_bcd", bus.bcd, 8'h99);
    pulse_up();
`ifdef UPDOWN_BCD_SATURATE_EN
    chk7("upwrap_count", bus.count, 7'd99);
    chk8("upwrap_bcd", bus.bcd, 8'h99);
`else
    chk7("upwrap_count", bus.count, 7'd0);
    chk8("upwrap_bcd", bus.bcd, 8'h00);
`endif

    // simultaneous edges
    do_reset();
    for (int i = 0; i < 50; i++) pulse_up();
    chk7("fifty", bus.count, 7'd50);
    step(1, 1, 1);
    step(1, 1, 1);
    chk7("both_count", bus.count, 7'd50);
    chk8("both_bcd", bus.bcd, 8'h50);
    step(1, 0, 1);
    step(1, 1, 1);
    step(1, 0, 1);
    chk7("minus_only_count", bus.count, 7'd49);
    chk8("minus_only_bcd", bus.bcd, 8'h49);
    step(0, 0, 1);

    // reset mid-count, plus high across release
    do_reset();
    for (int i = 0; i < 37; i++) pulse_up();
    chk8("pre_rst_bcd", bus.bcd, 8'h37);
    step(1, 0, 0);
    chk7("midrst_count", bus.count, 7'd0);
    chk8("midrst_bcd", bus.bcd, 8'h00);
    step(1, 0, 1);
    chk7("release_count", bus.count, 7'd1);
    step(1, 0, 1);
    chk7("release_hold", bus.count, 7'd1);
    chk8("release_bcd", bus.bcd, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
